// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, load-use bubble
// insertion, downstream hold and flush handling; drives the ALU inputs.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src_a,
    input  logic              id_alu_src_b,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_result,
    output logic              id_stall,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [XLEN-1:0]   ex_store_data
);

    typedef enum logic [1:0] {
        UPD_CAPTURE = 2'd0,
        UPD_HOLD    = 2'd1,
        UPD_BUBBLE  = 2'd2
    } upd_e;

    logic              valid_q,     valid_d;
    logic [XLEN-1:0]   pc_q,        pc_d;
    logic [XLEN-1:0]   rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]   imm_q,       imm_d;
    logic [REG_AW-1:0] rs1_addr_q,  rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q,  rs2_addr_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic [3:0]        alu_op_q,    alu_op_d;
    logic              src_a_q,     src_a_d;
    logic              src_b_q,     src_b_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              load_use;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    upd_e              upd;

    assign load_use = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid
                    & ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));
    assign id_stall = load_use | ex_hold;

    // MEM beats WB beats register file; x0 never matches
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs1_addr_q))
            fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_q))
            fwd_rs1 = wb_result;

        fwd_rs2 = rs2_data_q;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs2_addr_q))
            fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_q))
            fwd_rs2 = wb_result;
    end

    always_comb begin
        if (flush)
            upd = UPD_BUBBLE;
        else if (ex_hold)
            upd = UPD_HOLD;
        else if (load_use)
            upd = UPD_BUBBLE;
        else
            upd = UPD_CAPTURE;
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_op_d    = alu_op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        case (upd)
            UPD_BUBBLE: begin
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                alu_op_d    = '0;
                rd_addr_d   = '0;
            end
            UPD_HOLD: begin
                // re-latch forwarded operands so a retiring producer is not lost
                rs1_data_d = fwd_rs1;
                rs2_data_d = fwd_rs2;
            end
            default: begin
                valid_d     = id_valid;
                pc_d        = id_pc;
                rs1_data_d  = id_rs1_data;
                rs2_data_d  = id_rs2_data;
                imm_d       = id_imm;
                rs1_addr_d  = id_rs1_addr;
                rs2_addr_d  = id_rs2_addr;
                rd_addr_d   = id_rd_addr;
                alu_op_d    = id_alu_op;
                src_a_d     = id_alu_src_a;
                src_b_d     = id_alu_src_b;
                reg_write_d = id_reg_write;
                mem_read_d  = id_mem_read;
                mem_write_d = id_mem_write;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_op_q    <= '0;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_op_q    <= alu_op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // an invalid slot (e.g. id_valid=0 captured) presents no operation
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd_addr    = rd_addr_q;
    assign alu_op        = valid_q ? alu_op_q : 4'b0000;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_read   = valid_q & mem_read_q;
    assign ex_mem_write  = valid_q & mem_write_q;
    assign alu_a         = src_a_q ? pc_q  : fwd_rs1;
    assign alu_b         = src_b_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, forwarding priority, load-use
// bubble, flush/hold priority, hold across WB retire and async reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_mem_write;
    logic        flush, ex_hold;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic        id_stall;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd_addr;

    int tests_run = 0;
    int tests_failed = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_op(id_alu_op), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_hold(ex_hold),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [4:0] r1a, input logic [4:0] r2a, input logic [4:0] rd,
                          input logic [3:0] op, input logic sa, input logic sb,
                          input logic rw, input logic mr, input logic mw);
        id_valid = v;       id_pc = pc;         id_rs1_data = r1d;  id_rs2_data = r2d;
        id_imm = imm;       id_rs1_addr = r1a;  id_rs2_addr = r2a;  id_rd_addr = rd;
        id_alu_op = op;     id_alu_src_a = sa;  id_alu_src_b = sb;
        id_reg_write = rw;  id_mem_read = mr;   id_mem_write = mw;
    endtask

    task automatic clr_fwd();
        mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
        wb_reg_write  = 1'b0; wb_rd_addr  = '0; wb_result  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        clr_fwd();
        #2;
        chk("reset_valid", ex_valid, 0);
        chk("reset_alu_op", alu_op, 4'b0000);
        chk("reset_reg_write", ex_reg_write, 0);
        #1 rst_n = 1'b1;

        // plain capture, SUB
        set_id(1, 32'h100, 32'hAAAAAAAA, 32'hCCCCCCCC, 0, 5'd1, 5'd2, 5'd3, 4'b1000, 0, 0, 1, 0, 0);
        tick();
        chk("cap_alu_a", alu_a, 32'hAAAAAAAA);
        chk("cap_alu_b", alu_b, 32'hCCCCCCCC);
        chk("cap_alu_op", alu_op, 4'b1000);
        chk("cap_valid", ex_valid, 1);
        chk("cap_reg_write", ex_reg_write, 1);
        chk("cap_rd", ex_rd_addr, 5'd3);
        chk("cap_store", ex_store_data, 32'hCCCCCCCC);
        chk("cap_stall", id_stall, 0);

        // PC / immediate operand select, store
        set_id(1, 32'h200, 32'h1, 32'h2, 32'h10, 5'd1, 5'd2, 5'd0, 4'b0000, 1, 1, 0, 0, 1);
        tick();
        chk("sel_alu_a_pc", alu_a, 32'h200);
        chk("sel_alu_b_imm", alu_b, 32'h10);
        chk("sel_ex_pc", ex_pc, 32'h200);
        chk("sel_mem_write", ex_mem_write, 1);
        chk("sel_store_rs2", ex_store_data, 32'h2);

        // invalid slot shows no operation
        set_id(0, 32'h300, 0, 0, 0, 5'd1, 5'd2, 5'd4, 4'b1101, 0, 0, 1, 0, 0);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_alu_op", alu_op, 4'b0000);
        chk("inv_reg_write", ex_reg_write, 0);

        // forwarding priority on rs1 = x5, rs2 = x6
        set_id(1, 32'h400, 32'h11, 32'h22, 0, 5'd5, 5'd6, 5'd4, 4'b0000, 0, 0, 1, 0, 0);
        tick();
        mem_reg_write = 1; mem_rd_addr = 5'd5; mem_result = 32'h6A;
        wb_reg_write  = 1; wb_rd_addr  = 5'd5; wb_result  = 32'h4;
        #1 chk("fwd_mem_beats_wb", alu_a, 32'h6A);
        mem_rd_addr = 5'd0;
        #1 chk("fwd_mem_x0_wb", alu_a, 32'h4);
        wb_rd_addr = 5'd0;
        #1 chk("fwd_wb_x0_rf", alu_a, 32'h11);
        wb_rd_addr = 5'd6;
        #1 chk("fwd_wb_rs2", alu_b, 32'h4);
        chk("fwd_wb_store", ex_store_data, 32'h4);
        wb_reg_write = 0;
        #1 chk("fwd_wb_disabled", alu_b, 32'h22);
        clr_fwd();

        // load-use: EX = lw x7 ; ID = add x1,x7,x2
        set_id(1, 32'h500, 0, 0, 32'h40, 5'd0, 5'd0, 5'd7, 4'b0000, 0, 1, 1, 1, 0);
        tick();
        chk("lu_ex_load", ex_mem_read, 1);
        set_id(1, 32'h504, 32'hDEAD, 32'h5, 0, 5'd7, 5'd2, 5'd1, 4'b0000, 0, 0, 1, 0, 0);
        #1 chk("lu_stall", id_stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rw", ex_reg_write, 0);
        chk("lu_bubble_mr", ex_mem_read, 0);
        chk("lu_stall_released", id_stall, 0);
        tick();
        mem_reg_write = 1; mem_rd_addr = 5'd7; mem_result = 32'h1234;
        #1 chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_fwd_a", alu_a, 32'h1234);
        chk("lu_add_b", alu_b, 32'h5);
        chk("lu_add_pc", ex_pc, 32'h504);
        clr_fwd();

        // flush together with hold: bubble wins
        flush = 1; ex_hold = 1;
        #1 chk("fh_stall", id_stall, 1);
        tick();
        chk("fh_valid", ex_valid, 0);
        chk("fh_reg_write", ex_reg_write, 0);
        chk("fh_rd", ex_rd_addr, 0);
        flush = 0; ex_hold = 0;

        // hold across WB retire: AND x8,x3,imm
        set_id(1, 32'h600, 32'h1, 0, 32'hF0, 5'd3, 5'd0, 5'd8, 4'b0111, 0, 1, 1, 0, 0);
        tick();
        chk("hr_pre_a", alu_a, 32'h1);
        set_id(1, 32'h700, 32'h999, 0, 0, 5'd9, 5'd0, 5'd9, 4'b0000, 0, 0, 1, 0, 0);
        ex_hold = 1;
        wb_reg_write = 1; wb_rd_addr = 5'd3; wb_result = 32'hFFFF;
        #1 chk("hr_c1_a", alu_a, 32'hFFFF);
        tick();
        clr_fwd();
        #1 chk("hr_c2_a", alu_a, 32'hFFFF);
        chk("hr_c2_op", alu_op, 4'b0111);
        tick();
        chk("hr_c3_a", alu_a, 32'hFFFF);
        chk("hr_c3_pc", ex_pc, 32'h600);
        tick();
        chk("hr_end_a", alu_a, 32'hFFFF);
        chk("hr_end_valid", ex_valid, 1);
        ex_hold = 0;
        tick();
        chk("hr_release_a", alu_a, 32'h999);
        chk("hr_release_pc", ex_pc, 32'h700);

        // reset mid-run, away from any clock edge
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_valid", ex_valid, 0);
        chk("rst_mid_alu_op", alu_op, 4'b0000);
        chk("rst_mid_reg_write", ex_reg_write, 0);
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
